// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: turns a resolved EX-stage branch or jump into a
// PC redirect followed by a programmable number of wrong-path squash cycles.
// Optional macro BRANCH_STATS_EN enables the conditional-branch counters
// br_count / br_taken_count; without it both ports read as constant 0.
module branch_redirect_ctrl #(
   parameter int XLEN          = 32,
   parameter int SQUASH_CYCLES = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ex_valid,
   input  logic [2:0]      ex_itype,
   input  logic            ex_jump,
   input  logic            branchtaken,
   input  logic [XLEN-1:0] ex_target,
   input  logic            pipe_stall,
   output logic            pc_sel,
   output logic [XLEN-1:0] pc_target,
   output logic            flush_ifid,
   output logic            flush_idex,
   output logic            redirect_busy,
   output logic [31:0]     br_count,
   output logic [31:0]     br_taken_count
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REDIRECT = 2'd1,
      SQUASH   = 2'd2
   } state_t;

   localparam logic [2:0] SQ_INIT = 3'(SQUASH_CYCLES);

   state_t     state;
   logic [2:0] sq_cnt;
   logic       accept;
   logic       is_br;
   logic       redirect;

   // Resolutions are only looked at in IDLE; in the other states the EX
   // stage holds wrong-path instructions.
   assign accept   = (state == IDLE) && ex_valid && !pipe_stall;
   assign is_br    = (ex_itype == 3'd4);
   assign redirect = accept && ((is_br && branchtaken) || ex_jump);

   // Redirect FSM with registered control outputs and latched target.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         sq_cnt        <= 3'd0;
         pc_target     <= '0;
         pc_sel        <= 1'b0;
         flush_ifid    <= 1'b0;
         flush_idex    <= 1'b0;
         redirect_busy <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (redirect) begin
                  state         <= REDIRECT;
                  pc_target     <= ex_target;
                  pc_sel        <= 1'b1;
                  flush_ifid    <= 1'b1;
                  flush_idex    <= 1'b1;
                  redirect_busy <= 1'b1;
               end
            end
            REDIRECT: begin
               if (!pipe_stall) begin
                  pc_sel     <= 1'b0;
                  flush_ifid <= 1'b0;
                  if (SQUASH_CYCLES > 0) begin
                     state         <= SQUASH;
                     sq_cnt        <= SQ_INIT;
                     flush_idex    <= 1'b1;
                     redirect_busy <= 1'b1;
                  end else begin
                     state         <= IDLE;
                     flush_idex    <= 1'b0;
                     redirect_busy <= 1'b0;
                  end
               end
            end
            SQUASH: begin
               if (!pipe_stall) begin
                  // A count of 0 cannot occur here; treating it like 1 keeps
                  // the FSM from getting stuck if it ever did.
                  if (sq_cnt <= 3'd1) begin
                     state         <= IDLE;
                     sq_cnt        <= 3'd0;
                     flush_idex    <= 1'b0;
                     redirect_busy <= 1'b0;
                  end else begin
                     sq_cnt <= sq_cnt - 3'd1;
                  end
               end
            end
            default: begin
               state         <= IDLE;
               sq_cnt        <= 3'd0;
               pc_sel        <= 1'b0;
               flush_ifid    <= 1'b0;
               flush_idex    <= 1'b0;
               redirect_busy <= 1'b0;
            end
         endcase
      end
   end

`ifdef BRANCH_STATS_EN
   // Count accepted conditional branches and the taken subset; both wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         br_count       <= 32'd0;
         br_taken_count <= 32'd0;
      end else if (accept && is_br) begin
         br_count <= br_count + 32'd1;
         if (branchtaken) begin
            br_taken_count <= br_taken_count + 32'd1;
         end
      end
   end
`else
   assign br_count       = 32'd0;
   assign br_taken_count = 32'd0;
`endif

endmodule

// File: doc/branch_redirect_ctrl.md
BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning address width.
REQ-002 The block SHALL have parameter SQUASH_CYCLES, default 1, range 0..7, meaning extra wrong-path cycles squashed after a redirect.
REQ-003 The block SHALL have these ports, listed as name, direction, width and meaning:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  EX-stage instruction is valid.
- ex_itype  in  3  EX-stage instruction type; value 4 means conditional branch.
- ex_jump  in  1  EX-stage instruction is an unconditional jump.
- branchtaken  in  1  branch-unit condition result for the EX-stage instruction.
- ex_target  in  XLEN  resolved target address.
- pipe_stall  in  1  global pipeline freeze.
- pc_sel  out  1  selects pc_target as the next PC.
- pc_target  out  XLEN  latched redirect address.
- flush_ifid  out  1  squashes the IF/ID register.
- flush_idex  out  1  squashes the ID/EX register.
- redirect_busy  out  1  high whenever state is not IDLE.
- br_count  out  32  number of accepted conditional branches.
- br_taken_count  out  32  number of accepted taken conditional branches.

Function
REQ-004 The block SHALL implement an FSM with the states IDLE, REDIRECT and SQUASH.
REQ-005 A resolution SHALL be accepted only in IDLE with ex_valid=1 and pipe_stall=0.
REQ-006 An accepted resolution SHALL be a redirect when (ex_itype==4 and branchtaken=1) or ex_jump=1; branchtaken SHALL be ignored when ex_itype!=4.
REQ-007 On an accepted redirect at edge N, the block SHALL latch ex_target into pc_target and enter REDIRECT, so that outputs are visible in cycle N+1; the latency is 1 cycle.
REQ-008 In REDIRECT the block SHALL assert pc_sel=1, flush_ifid=1 and flush_idex=1.
REQ-009 REDIRECT SHALL hold, with its outputs held, while pipe_stall=1, and SHALL exit on the first edge with pipe_stall=0: to SQUASH when SQUASH_CYCLES>0, otherwise to IDLE.
REQ-010 On entering SQUASH, the block SHALL load a 3-bit counter with SQUASH_CYCLES.
REQ-011 In SQUASH the block SHALL assert flush_idex=1 only, and SHALL decrement the counter on each edge with pipe_stall=0.
REQ-012 SQUASH SHALL exit to IDLE on the edge where the counter is 1 and pipe_stall=0.
REQ-013 In REDIRECT and SQUASH, ex_valid, ex_itype, ex_jump and branchtaken SHALL be ignored, because they belong to wrong-path instructions.
REQ-014 In IDLE, pc_sel, flush_ifid and flush_idex SHALL be 0, and a non-redirecting resolution SHALL leave the state unchanged.
REQ-015 pc_target SHALL change only when a redirect is accepted.
REQ-016 redirect_busy SHALL be 1 exactly in REDIRECT and SQUASH.
REQ-017 All outputs SHALL be driven from registered state only, with no combinational path from any input to any output.

Reset
REQ-018 While rst=1 at an edge, the block SHALL go to state IDLE, clear the squash counter to 0, clear pc_target to 0 and clear both counters to 0.
REQ-019 After reset, pc_sel, flush_ifid, flush_idex and redirect_busy SHALL be 0.
REQ-020 Reset SHALL take priority over every other event, including an accepted redirect in the same cycle.
REQ-021 A reset asserted in REDIRECT or SQUASH SHALL abort the sequence, with no further flush or pc_sel asserted.

Configuration
REQ-022 With macro BRANCH_STATS_EN defined, the block SHALL increment br_count on each accepted resolution with ex_itype==4.
REQ-023 With BRANCH_STATS_EN defined, the block SHALL also increment br_taken_count when that accepted branch has branchtaken=1.
REQ-024 Both counters SHALL wrap modulo 2^32.
REQ-025 Without BRANCH_STATS_EN, br_count and br_taken_count SHALL be tied to 0, and no counter registers SHALL be synthesized; the port list SHALL be unchanged.

Verification
REQ-026 The bench SHALL cover: a taken branch (ex_valid=1, ex_itype=4, branchtaken=1, ex_target=0x100) with SQUASH_CYCLES=1 -> next cycle pc_sel=1, flush_ifid=1, flush_idex=1 and pc_target=0x100; the cycle after, flush_idex=1 only; then IDLE.
REQ-027 The bench SHALL cover: a not-taken branch (ex_itype=4, branchtaken=0) -> no flush, and with BRANCH_STATS_EN br_count=1 and br_taken_count=0.
REQ-028 The bench SHALL cover: ex_itype=2 with branchtaken=1 -> no redirect and no count change.
REQ-029 The bench SHALL cover: pipe_stall=1 for 3 cycles during REDIRECT -> pc_sel and both flushes held for 4 cycles, then SQUASH.
REQ-030 The bench SHALL cover: ex_jump=1 with ex_target=0x200 presented during SQUASH -> ignored, and pc_target stays at the first target.
REQ-031 The bench SHALL cover: rst=1 in REDIRECT -> next cycle all outputs 0 and state IDLE; with SQUASH_CYCLES=0, a taken branch gives exactly 1 flush cycle.
